// File: rtl/traffic_request_gen.sv
// traffic_request_gen: sensor front end producing the V (vehicle waiting) and Z (emergency)
// requests for traffic_light_fsm. Raw detector inputs are synchronized and debounced. Vehicle
// arrivals are queued in a saturating counter, and emergency requests are held by a small FSM.
// Requests are released only when the controller pulses served_v / served_z.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   veh_raw    raw vehicle detector (asynchronous, may bounce)
//   emg_raw    raw emergency preempt input (asynchronous, may bounce)
//   served_v   one-cycle pulse: one queued vehicle served
//   served_z   one-cycle pulse: emergency preempt completed
//   V          registered vehicle request (queue non-empty)
//   Z          registered emergency request
//   veh_count  queued vehicles, saturating at 7
//   emg_state  emergency FSM state: 00 idle, 01 active, 10 hold
module traffic_request_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned Z_HOLD_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       veh_raw,
  input  logic       emg_raw,
  input  logic       served_v,
  input  logic       served_z,
  output logic       V,
  output logic       Z,
  output logic [2:0] veh_count,
  output logic [1:0] emg_state
);

  localparam logic [3:0] DbLast   = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] HoldLoad = 4'(Z_HOLD_CYCLES);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StActive = 2'b01,
    StHold   = 2'b10
  } emg_state_e;

  // Bit 0 carries the vehicle channel, bit 1 the emergency channel.
  logic [1:0] raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] db_q, db_prev_q;
  logic [3:0] db_cnt_q [2];
  logic [1:0] rise;

  logic       veh_arr, veh_dec;
  logic       emg_rise, emg_low;
  logic [2:0] count_q, count_d;
  logic       v_q, z_q;

  emg_state_e state_q, state_d;
  logic [3:0] hold_q, hold_d;

  assign raw = {emg_raw, veh_raw};

  // Synchronizers and debouncers: the debounced level flips only after the synchronized value
  // has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      db_prev_q   <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast) begin
          db_q[i]     <= ~db_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign rise     = db_q & ~db_prev_q;
  assign veh_arr  = rise[0];
  assign emg_rise = rise[1];
  assign emg_low  = ~db_q[1];

  // Vehicle queue: an arrival coinciding with a real service cancels out; an arrival at 7 is
  // dropped, and a service at 0 is ignored.
  always_comb begin
    veh_dec = served_v && (count_q != 3'd0);
    count_d = count_q;
    if (veh_arr && !veh_dec) begin
      if (count_q != 3'd7) count_d = count_q + 3'd1;
    end else if (!veh_arr && veh_dec) begin
      count_d = count_q - 3'd1;
    end
  end

  // Emergency FSM next state. A fresh rising edge always wins over served_z.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (emg_rise) state_d = StActive;
      end
      StActive: begin
        if (emg_rise) begin
          state_d = StActive;
        end else if (served_z) begin
          state_d = StIdle;
        end else if (emg_low) begin
          state_d = StHold;
          hold_d  = HoldLoad;
        end
      end
      StHold: begin
        if (emg_rise) begin
          state_d = StActive;
          hold_d  = '0;
        end else if (served_z) begin
          state_d = StIdle;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - 4'd1;
          if (hold_q == 4'd1) state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      v_q     <= 1'b0;
      state_q <= StIdle;
      hold_q  <= '0;
      z_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      v_q     <= (count_d != 3'd0);
      state_q <= state_d;
      hold_q  <= hold_d;
      z_q     <= (state_d != StIdle);
    end
  end

  assign V         = v_q;
  assign Z         = z_q;
  assign veh_count = count_q;
  assign emg_state = state_q;

endmodule

// File: tb/tb_traffic_request_gen.sv
// Bench for traffic_request_gen: directed scenarios followed by random bouncing inputs. The
// driver applies inputs on the falling edge and pushes the reference model's expected outputs
// for the coming rising edge; an independent monitor pops and compares just after each edge.
module tb_traffic_request_gen;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Hold = 8;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       veh_raw  = 1'b0;
  logic       emg_raw  = 1'b0;
  logic       served_v = 1'b0;
  logic       served_z = 1'b0;
  logic       V, Z;
  logic [2:0] veh_count;
  logic [1:0] emg_state;

  traffic_request_gen #(
    .DEBOUNCE_CYCLES(Deb),
    .Z_HOLD_CYCLES  (Hold)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .veh_raw  (veh_raw),
    .emg_raw  (emg_raw),
    .served_v (served_v),
    .served_z (served_z),
    .V        (V),
    .Z        (Z),
    .veh_count(veh_count),
    .emg_state(emg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       z;
    logic [2:0] cnt;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];
  exp_t mx;
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model. Each channel keeps the raw samples seen two cycles late (what the
  // synchronizer delivers) in a bit window; the level flips once the last Deb samples since the
  // previous flip all disagree with it. Rising flips become arrivals one edge later.
  int        edge_n = 0;
  bit        d1   [2];
  bit        d2   [2];
  bit        lvl  [2];
  bit        rose [2];
  bit [15:0] win  [2];
  int        tchg [2];
  int        m_cnt  = 0;
  int        m_mode = 0;  // 0 idle, 1 active, 2 hold
  int        m_left = 0;

  task automatic model_edge(input bit r, input bit v, input bit e, input bit sv, input bit sz);
    bit        rw [2];
    bit        s;
    bit        arr, erise, elow;
    bit [15:0] mask;
    exp_t      x;
    rw[0] = v;
    rw[1] = e;
    edge_n++;
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        d1[i] = 0; d2[i] = 0; lvl[i] = 0; rose[i] = 0; win[i] = '0; tchg[i] = edge_n;
      end
      m_cnt = 0; m_mode = 0; m_left = 0;
    end else begin
      arr   = rose[0];
      erise = rose[1];
      elow  = !lvl[1];
      mask  = 16'((1 << Deb) - 1);
      for (int i = 0; i < 2; i++) begin
        s      = d2[i];
        d2[i]  = d1[i];
        d1[i]  = rw[i];
        win[i] = {win[i][14:0], s};
        rose[i] = 0;
        if ((edge_n - int'(Deb) >= tchg[i]) &&
            ((win[i] & mask) == (lvl[i] ? 16'h0000 : mask))) begin
          lvl[i]  = !lvl[i];
          rose[i] = lvl[i];
          tchg[i] = edge_n;
        end
      end
      if (arr && !(sv && m_cnt > 0)) m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
      else if (!arr && sv && m_cnt > 0) m_cnt = m_cnt - 1;
      if (erise) m_mode = 1;
      else if (m_mode != 0 && sz) m_mode = 0;
      else if (m_mode == 1 && elow) begin
        m_mode = 2;
        m_left = Hold;
      end else if (m_mode == 2) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 0;
      end
    end
    x.v   = (m_cnt != 0);
    x.z   = (m_mode != 0);
    x.cnt = 3'(m_cnt);
    x.st  = 2'(m_mode);
    exp_q.push_back(x);
  endtask

  task automatic cyc(input bit r, input bit v, input bit e, input bit sv, input bit sz);
    @(negedge clk);
    rst      = r;
    veh_raw  = v;
    emg_raw  = e;
    served_v = sv;
    served_z = sz;
    model_edge(r, v, e, sv, sz);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic veh_pulse();
    repeat (10) cyc(0, 1, 0, 0, 0);
    idle(10);
  endtask

  // Monitor: compare every presented output set against the queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mx = exp_q.pop_front();
        vectors++;
        if (V !== mx.v) begin
          miscompares++;
          $display("FAIL V at %0t: got %b expected %b", $time, V, mx.v);
        end
        if (Z !== mx.z) begin
          miscompares++;
          $display("FAIL Z at %0t: got %b expected %b", $time, Z, mx.z);
        end
        if (veh_count !== mx.cnt) begin
          miscompares++;
          $display("FAIL veh_count at %0t: got %0d expected %0d", $time, veh_count, mx.cnt);
        end
        if (emg_state !== mx.st) begin
          miscompares++;
          $display("FAIL emg_state at %0t: got %b expected %b", $time, emg_state, mx.st);
        end
      end
    end
  end

  initial begin
    bit vr, er, vb, eb, rr;
    vr = 0;
    er = 0;

    // Reset held with raw inputs high, then released with them still high.
    repeat (3) cyc(1, 1, 1, 0, 0);
    repeat (12) cyc(0, 1, 1, 0, 0);
    idle(30);
    cyc(0, 0, 0, 1, 0);
    idle(3);

    // Short glitch must not register.
    repeat (3) cyc(0, 1, 0, 0, 0);
    idle(10);

    // Saturation: 9 arrivals, then 8 services.
    repeat (9) veh_pulse();
    repeat (8) begin
      cyc(0, 0, 0, 1, 0);
      idle(2);
    end

    // Arrival coinciding with service at count 2, then at count 0.
    repeat (2) veh_pulse();
    for (int k = 1; k <= 10; k++) cyc(0, 1, 0, (k == int'(Deb) + 3), 0);
    idle(10);
    repeat (2) begin
      cyc(0, 0, 0, 1, 0);
      idle(2);
    end
    for (int k = 1; k <= 10; k++) cyc(0, 1, 0, (k == int'(Deb) + 3), 0);
    idle(10);
    cyc(0, 0, 0, 1, 0);
    idle(3);

    // Emergency hold expiry, then re-raise during hold.
    repeat (20) cyc(0, 0, 1, 0, 0);
    idle(30);
    repeat (20) cyc(0, 0, 1, 0, 0);
    idle(4);
    repeat (20) cyc(0, 0, 1, 0, 0);
    idle(30);

    // Served preempt while level still high; needs a new rising edge to re-request.
    repeat (15) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1);
    repeat (10) cyc(0, 0, 1, 0, 0);
    idle(10);
    repeat (15) cyc(0, 0, 1, 0, 0);
    idle(30);

    // Reset mid-operation discards pending requests.
    repeat (3) veh_pulse();
    repeat (12) cyc(0, 0, 1, 0, 0);
    repeat (2) cyc(1, 1, 1, 0, 0);
    idle(20);

    // Random bouncing inputs with random services and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(11) == 0) vr = ~vr;
      if ($urandom_range(15) == 0) er = ~er;
      vb = vr ^ ($urandom_range(9) == 0);
      eb = er ^ ($urandom_range(9) == 0);
      rr = ($urandom_range(699) == 0);
      cyc(rr, vb, eb, ($urandom_range(8) == 0), ($urandom_range(24) == 0));
    end
    idle(3);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_request_gen.md
Name: traffic_request_gen

Overview:
- Sensor front end that produces the V (vehicle waiting) and Z (emergency) request inputs consumed by traffic_light_fsm.
- Synchronizes and debounces raw detector inputs, queues vehicle arrivals and holds emergency requests.
- Requests are released only when the controller reports them served.
- Sits between the board I/O pins and the controller; V and Z drive the controller's ports directly.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required to change a debounced level (legal range 2..15).
- Z_HOLD_CYCLES, 8, cycles Z stays asserted after the debounced emergency input falls (legal range 1..15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- veh_raw  input  1  raw vehicle detector; asynchronous, may bounce.
- emg_raw  input  1  raw emergency preempt input; asynchronous, may bounce.
- served_v  input  1  single-cycle pulse from controller: one waiting vehicle served.
- served_z  input  1  single-cycle pulse from controller: emergency preempt completed.
- V  output  1  vehicle request to controller; registered.
- Z  output  1  emergency request to controller; registered.
- veh_count  output  3  vehicles queued, saturating.
- emg_state  output  2  emergency FSM state: IDLE=00, ACTIVE=01, HOLD=10.

Behaviour:
- Reset (async assert, sync release):
  - All synchronizer, debounce, counter and FSM registers clear.
  - V=0, Z=0, veh_count=0, emg_state=IDLE.
  - Reset asserted mid-operation discards all pending requests; nothing is remembered after release.
- Synchronizer: each raw input passes through a 2-flop synchronizer; reset value 0.
- Debounce, per input:
  - A 4-bit counter increments each cycle the synchronized value differs from the debounced level.
  - The counter clears on any cycle where they match.
  - When the counter equals DEBOUNCE_CYCLES-1 and a mismatch persists, the debounced level toggles and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES synchronized cycles never change the debounced level.
- Edge detect: an arrival pulse is the rising edge of the debounced level (debounced & ~registered debounced).
- Vehicle queue:
  - Next count = count + arrival - (served_v && count != 0), saturating at 7.
  - served_v with count 0 is ignored.
  - Arrival and served_v in the same cycle leave a nonzero count unchanged; with count 0 the count becomes 1.
  - At count 7, a further arrival is dropped.
  - V is registered and equals (next count != 0), so V changes on the same edge as veh_count.
- Latency: with veh_raw rising cleanly before edge 1, veh_count and V update at edge DEBOUNCE_CYCLES+3 (edge 7 for the default).
- Emergency FSM:
  - IDLE: emg debounced rising edge -> ACTIVE.
  - ACTIVE: debounced emg falls -> HOLD, hold counter loaded with Z_HOLD_CYCLES.
  - HOLD: counter decrements each cycle and moves to IDLE when it reaches 1 and decrements. A new rising edge returns to ACTIVE and clears the counter.
  - served_z in ACTIVE or HOLD -> IDLE.
  - A rising edge in the same cycle as served_z wins -> ACTIVE.
  - After served_z, a level that is still high does not re-request; a new rising edge is required.
  - Z = 1 in ACTIVE and HOLD, 0 in IDLE; Z is registered from the next state.
- Priority: Z does not mask V or freeze the vehicle queue; arbitration belongs to the controller.
- All outputs are glitch-free register outputs.

Test Plan:
- Reset: hold rst=1 with veh_raw=1, emg_raw=1 -> V=0, Z=0, veh_count=0, emg_state=00. Release, raw inputs held high -> V=1 at edge 7 and Z=1 at edge 7 after release.
- Glitch: veh_raw high for 3 cycles, then low -> veh_count stays 0 and V stays 0.
- Queue saturation: 9 clean veh_raw pulses (each 10 high/10 low cycles) -> veh_count=7. Then 7 served_v pulses -> count reaches 0 and V drops on the edge of the 7th pulse. An 8th served_v leaves count 0.
- Simultaneous: veh_count=2, arrival pulse coincides with served_v -> veh_count stays 2. With count 0, coincident arrival and served_v -> count 1, V=1.
- Emergency hold: emg_raw high for 20 cycles, then low, no served_z -> emg_state 01 -> 10, Z stays 1 exactly 8 cycles after the debounced fall, then 00 and Z=0. Re-raising emg_raw during HOLD -> back to 01.
- Served preempt: in ACTIVE with emg_raw still high, pulse served_z -> emg_state=00 and Z=0 next edge, Z remains 0 until emg_raw falls and rises again.
